// File: rtl/elevator_request_dispatcher_pkg.sv
// Shared types and constants for the elevator request dispatcher slice.
// Floors, queued requests and the dispatcher state encoding live here.
package elevator_pkg;

  localparam int FLOOR_W     = 3;
  localparam int ACK_TIMEOUT = 8;

  typedef logic [FLOOR_W-1:0] floor_t;

  typedef struct packed {
    floor_t origin;
    floor_t dest;
  } request_t;

  typedef enum logic [1:0] {
    S_WAIT,
    S_ISSUE,
    S_ACK,
    S_RUN
  } dispatch_state_e;

endpackage

// File: rtl/elevator_request_dispatcher_if.sv
// Request-side valid/ready channel between a request source and the dispatcher.
interface elevator_request_dispatcher_if;
  import elevator_pkg::*;

  logic   req_valid;
  logic   req_ready;
  logic   req_error;
  floor_t req_origin;
  floor_t req_dest;

  modport master (output req_valid, req_origin, req_dest, input req_ready, req_error);
  modport slave  (input req_valid, req_origin, req_dest, output req_ready, req_error);

endinterface

// File: rtl/elevator_request_dispatcher_fifo.sv
// Circular request FIFO with wrap-around pointers, flush and occupancy count.
module elevator_req_fifo
  import elevator_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  request_t      wdata,
  output request_t      rdata,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  localparam int PW = $clog2(DEPTH);

  request_t        mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic            do_push;
  logic            do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/elevator_request_dispatcher.sv
// Validates and queues elevator requests, then hands them one at a time to the car controller.
module elevator_request_dispatcher
  import elevator_pkg::*;
#(
  parameter  int DEPTH      = 4,
  parameter  int NUM_FLOORS = 5,
  localparam int CW         = $clog2(DEPTH + 1)
) (
  input  logic                          clk,
  input  logic                          reset,
  elevator_request_dispatcher_if.slave  req,
  input  logic                          flush,
  input  logic                          elev_idle,
  output logic                          elev_en,
  output floor_t                        elev_origin,
  output floor_t                        elev_destination,
  output logic [CW-1:0]                 count,
  output logic                          busy
);

  localparam int             TW       = $clog2(ACK_TIMEOUT);
  localparam logic [TW-1:0]  ACK_LAST = TW'(ACK_TIMEOUT - 2);

  dispatch_state_e state, next_state;
  request_t        in_req;
  request_t        head;
  logic            full;
  logic            empty;
  logic            fire;
  logic            bad;
  logic            pop;
  logic [TW-1:0]   ack_timer;

  assign in_req        = '{origin: req.req_origin, dest: req.req_dest};
  assign req.req_ready = !full;
  assign fire          = req.req_valid && !full;
  assign bad           = (int'(in_req.origin) >= NUM_FLOORS) ||
                         (int'(in_req.dest) >= NUM_FLOORS) ||
                         (in_req.origin == in_req.dest);

  elevator_req_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fire && !bad && !flush),
    .pop   (pop),
    .flush (flush),
    .wdata (in_req),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  // A flush swallows a simultaneous request silently, so it never reports an error.
  always_ff @(posedge clk) begin
    if (reset) req.req_error <= 1'b0;
    else       req.req_error <= fire && bad && !flush;
  end

  always_comb begin
    next_state = state;
    pop        = 1'b0;
    unique case (state)
      S_WAIT: begin
        if (!empty && elev_idle) begin
          pop        = 1'b1;
          next_state = S_ISSUE;
        end
      end
      S_ISSUE: next_state = S_ACK;
      S_ACK: begin
        if (!elev_idle)                 next_state = S_RUN;
        else if (ack_timer == ACK_LAST) next_state = S_ISSUE;
      end
      S_RUN: begin
        if (elev_idle) next_state = S_WAIT;
      end
      default: next_state = S_WAIT;
    endcase
  end

  // The start pulse trails S_ISSUE by a cycle, so the timeout window spans ISSUE plus ACK.
  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= S_WAIT;
      ack_timer        <= '0;
      elev_en          <= 1'b0;
      busy             <= 1'b0;
      elev_origin      <= '0;
      elev_destination <= '0;
    end else begin
      state     <= next_state;
      elev_en   <= (state == S_ISSUE);
      busy      <= (next_state != S_WAIT);
      ack_timer <= (state == S_ACK) ? ack_timer + 1'b1 : '0;
      if (pop) begin
        elev_origin      <= head.origin;
        elev_destination <= head.dest;
      end
    end
  end

endmodule

// File: tb/tb_elevator_request_dispatcher.sv
// Directed bench for elevator_request_dispatcher with a trip-level reference model checked every cycle.
module tb_elevator_request_dispatcher;
  import elevator_pkg::*;

  localparam int DEPTH      = 4;
  localparam int NUM_FLOORS = 5;
  localparam int CW         = $clog2(DEPTH + 1);
  localparam int TRIP       = 4;

  typedef struct {
    int cyc;
    int o;
    int d;
  } ent_t;

  logic          clk       = 1'b0;
  logic          reset     = 1'b1;
  logic          flush     = 1'b0;
  logic          elev_idle = 1'b1;
  logic          elev_en;
  logic          busy;
  floor_t        elev_origin;
  floor_t        elev_destination;
  logic [CW-1:0] count;

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  bit   auto_ack   = 1'b1;
  bit   idle_force = 1'b1;
  int   trip_cnt   = 0;
  ent_t en_log[$];

  elevator_request_dispatcher_if req_if ();

  elevator_request_dispatcher #(.DEPTH(DEPTH), .NUM_FLOORS(NUM_FLOORS)) dut (
    .clk              (clk),
    .reset            (reset),
    .req              (req_if),
    .flush            (flush),
    .elev_idle        (elev_idle),
    .elev_en          (elev_en),
    .elev_origin      (elev_origin),
    .elev_destination (elev_destination),
    .count            (count),
    .busy             (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic reportTimeout(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s: wait expired", name);
  endtask

  // Present one request; with hold set, keep it up until the dispatcher can take it.
  task automatic applyStimulus(input int o, input int d, input bit hold);
    int budget = 60;
    @(negedge clk);
    req_if.req_valid  = 1'b1;
    req_if.req_origin = floor_t'(o);
    req_if.req_dest   = floor_t'(d);
    while (hold && !req_if.req_ready && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (budget == 0) reportTimeout("push_ready");
    @(negedge clk);
    req_if.req_valid = 1'b0;
  endtask

  task automatic waitIdleEmpty(input string name);
    int budget = 200;
    while ((busy || count != 0) && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (budget == 0) reportTimeout(name);
  endtask

  task automatic waitLog(input int n, input string name);
    int budget = 300;
    while (en_log.size() < n && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (budget == 0) reportTimeout(name);
  endtask

  // Fake car controller: in auto mode it acks each start pulse and finishes the trip after TRIP cycles.
  always @(negedge clk) begin
    if (!auto_ack) begin
      elev_idle = idle_force;
      trip_cnt  = 0;
    end else if (trip_cnt > 0) begin
      trip_cnt--;
      elev_idle = (trip_cnt == 0);
    end else if (elev_en) begin
      elev_idle = 1'b0;
      trip_cnt  = TRIP;
    end else begin
      elev_idle = 1'b1;
    end
  end

  // Reference model: a queue of accepted requests plus the progress of the current trip.
  request_t mq[$];
  bit       m_busy, m_en, m_err, m_pulse_due, m_waiting_ack, m_running;
  int       m_since_pulse;
  int       m_org, m_dst;

  always @(posedge clk) begin : model
    request_t r, h;
    bit fire, invalid;
    r.origin = req_if.req_origin;
    r.dest   = req_if.req_dest;
    fire     = req_if.req_valid && (mq.size() < DEPTH);
    invalid  = (int'(r.origin) >= NUM_FLOORS) || (int'(r.dest) >= NUM_FLOORS) || (r.origin == r.dest);
    if (reset) begin
      mq.delete();
      m_busy = 0; m_en = 0; m_err = 0; m_pulse_due = 0;
      m_waiting_ack = 0; m_running = 0; m_since_pulse = 0;
      m_org = 0; m_dst = 0;
    end else begin
      m_err = fire && invalid && !flush;
      m_en  = 0;
      if (!m_busy) begin
        if (mq.size() > 0 && elev_idle) begin
          h = mq.pop_front();
          m_org = int'(h.origin);
          m_dst = int'(h.dest);
          m_busy = 1;
          m_pulse_due = 1;
        end
      end else if (m_pulse_due) begin
        m_pulse_due = 0;
        m_en = 1;
        m_since_pulse = 0;
        m_waiting_ack = 1;
      end else if (m_waiting_ack) begin
        m_since_pulse++;
        if (!elev_idle) begin
          m_waiting_ack = 0;
          m_running = 1;
        end else if (m_since_pulse == ACK_TIMEOUT - 1) begin
          m_waiting_ack = 0;
          m_pulse_due = 1;
        end
      end else if (m_running && elev_idle) begin
        m_running = 0;
        m_busy = 0;
      end
      if (fire && !invalid && !flush) mq.push_back(r);
      if (flush) mq.delete();
    end
  end

  always @(negedge clk) begin : compare
    checkOutput("count", 32'(count), 32'(mq.size()));
    checkOutput("req_ready", 32'(req_if.req_ready), 32'(mq.size() < DEPTH));
    checkOutput("req_error", 32'(req_if.req_error), 32'(m_err));
    checkOutput("busy", 32'(busy), 32'(m_busy));
    checkOutput("elev_en", 32'(elev_en), 32'(m_en));
    checkOutput("elev_origin", 32'(elev_origin), 32'(m_org));
    checkOutput("elev_destination", 32'(elev_destination), 32'(m_dst));
    if (elev_en === 1'b1) en_log.push_back('{cyc, int'(elev_origin), int'(elev_destination)});
  end

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    int exp_o[10];
    int exp_d[10];
    req_if.req_valid  = 1'b0;
    req_if.req_origin = '0;
    req_if.req_dest   = '0;

    // 1. reset values, single dispatch latency and held destination
    repeat (2) @(negedge clk);
    checkOutput("rst_en", 32'(elev_en), 0);
    checkOutput("rst_origin", 32'(elev_origin), 0);
    checkOutput("rst_dest", 32'(elev_destination), 0);
    checkOutput("rst_error", 32'(req_if.req_error), 0);
    checkOutput("rst_busy", 32'(busy), 0);
    checkOutput("rst_ready", 32'(req_if.req_ready), 1);
    checkOutput("rst_count", 32'(count), 0);
    reset = 1'b0;
    @(negedge clk);
    $display("[TB] test 1: single request");
    applyStimulus(1, 4, 1'b1);
    checkOutput("t1_count_after_accept", 32'(count), 1);
    @(negedge clk);
    checkOutput("t1_en_cycle2", 32'(elev_en), 0);
    checkOutput("t1_origin", 32'(elev_origin), 1);
    checkOutput("t1_dest", 32'(elev_destination), 4);
    @(negedge clk);
    checkOutput("t1_en_cycle3", 32'(elev_en), 1);
    @(negedge clk);
    checkOutput("t1_en_after", 32'(elev_en), 0);
    waitIdleEmpty("t1_trip_end");
    checkOutput("t1_dest_held", 32'(elev_destination), 4);
    checkOutput("t1_pulses", 32'(en_log.size()), 1);

    // 2. malformed requests
    $display("[TB] test 2: rejected requests");
    en_log.delete();
    applyStimulus(2, 2, 1'b0);
    checkOutput("t2_err_same_floor", 32'(req_if.req_error), 1);
    applyStimulus(6, 0, 1'b0);
    checkOutput("t2_err_bad_floor", 32'(req_if.req_error), 1);
    checkOutput("t2_count", 32'(count), 0);
    @(negedge clk);
    checkOutput("t2_err_clears", 32'(req_if.req_error), 0);
    repeat (4) @(negedge clk);
    checkOutput("t2_no_en", 32'(en_log.size()), 0);

    // 3. fill while the car is busy, then drain in order
    $display("[TB] test 3: full queue");
    idle_force = 1'b0;
    auto_ack   = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 4; i++) applyStimulus(i, i + 1, 1'b1);
    checkOutput("t3_count_full", 32'(count), 4);
    checkOutput("t3_ready_low", 32'(req_if.req_ready), 0);
    applyStimulus(4, 0, 1'b0);
    checkOutput("t3_fifth_dropped", 32'(count), 4);
    en_log.delete();
    auto_ack = 1'b1;
    waitLog(4, "t3_drain");
    waitIdleEmpty("t3_idle");
    checkOutput("t3_dispatches", 32'(en_log.size()), 4);
    for (int i = 0; i < 4 && i < en_log.size(); i++) begin
      checkOutput("t3_order_origin", 32'(en_log[i].o), 32'(i));
      checkOutput("t3_order_dest", 32'(en_log[i].d), 32'(i + 1));
    end

    // 4. ten back-to-back requests across pointer wrap
    $display("[TB] test 4: wrap-around");
    en_log.delete();
    for (int i = 0; i < 10; i++) begin
      exp_o[i] = i % 5;
      exp_d[i] = (i % 5 + 1 + i % 3) % 5;
    end
    for (int i = 0; i < 10; i++) applyStimulus(exp_o[i], exp_d[i], 1'b1);
    waitLog(10, "t4_drain");
    waitIdleEmpty("t4_idle");
    checkOutput("t4_dispatches", 32'(en_log.size()), 10);
    for (int i = 0; i < 10 && i < en_log.size(); i++) begin
      checkOutput("t4_origin", 32'(en_log[i].o), 32'(exp_o[i]));
      checkOutput("t4_dest", 32'(en_log[i].d), 32'(exp_d[i]));
    end
    checkOutput("t4_last_origin", 32'(elev_origin), 4);
    checkOutput("t4_last_dest", 32'(elev_destination), 0);

    // 5. no acknowledgement: start pulse repeats
    $display("[TB] test 5: ack timeout");
    idle_force = 1'b1;
    auto_ack   = 1'b0;
    repeat (2) @(negedge clk);
    en_log.delete();
    applyStimulus(0, 3, 1'b1);
    waitLog(2, "t5_repulse");
    if (en_log.size() >= 2) checkOutput("t5_repulse_gap", 32'(en_log[1].cyc - en_log[0].cyc), 8);
    idle_force = 1'b0;
    repeat (3) @(negedge clk);
    idle_force = 1'b1;
    waitIdleEmpty("t5_idle");

    // 6. flush mid-trip keeps the in-flight request
    $display("[TB] test 6: flush");
    idle_force = 1'b0;
    repeat (2) @(negedge clk);
    applyStimulus(1, 3, 1'b1);
    applyStimulus(2, 4, 1'b1);
    applyStimulus(3, 0, 1'b1);
    checkOutput("t6_count", 32'(count), 3);
    en_log.delete();
    idle_force = 1'b1;
    waitLog(1, "t6_dispatch");
    idle_force = 1'b0;
    repeat (2) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    checkOutput("t6_count_flushed", 32'(count), 0);
    checkOutput("t6_busy", 32'(busy), 1);
    checkOutput("t6_dest_held", 32'(elev_destination), 3);
    checkOutput("t6_origin_held", 32'(elev_origin), 1);
    idle_force = 1'b1;
    repeat (12) @(negedge clk);
    checkOutput("t6_single_dispatch", 32'(en_log.size()), 1);
    checkOutput("t6_busy_done", 32'(busy), 0);

    // 7. reset during a trip
    $display("[TB] test 7: reset mid-trip");
    en_log.delete();
    applyStimulus(2, 4, 1'b1);
    waitLog(1, "t7_dispatch");
    idle_force = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkOutput("t7_busy", 32'(busy), 0);
    checkOutput("t7_origin", 32'(elev_origin), 0);
    checkOutput("t7_dest", 32'(elev_destination), 0);
    checkOutput("t7_ready", 32'(req_if.req_ready), 1);
    idle_force = 1'b1;
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
